uart_byte_port: RTL and testbench

- User-logic endpoint of the board-level UART byte interface. It drives txdata/txclk against the wrapper's txready and consumes rxdata/rxready by pulsing rxclk.
- Sits inside the top design and clocks from the slow system clock. Both UART handshakes run asynchronously to it, in the serial-clock domain.
- Provides DEPTH-entry TX and RX byte FIFOs so top-level logic can write and read single-cycle strobes without tracking the handshakes.

---
 rtl/uart_byte_port.sv | 193 +++++++++++++++++++
 tb/tb_uart_byte_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_port.sv
// User-side endpoint of the board UART byte interface: TX and RX byte FIFOs
// feeding two handshake FSMs that talk to the serial-clock-domain wrapper.
module uart_byte_port #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_wdata,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_empty,
  output logic [7:0] rx_rdata,
  input  logic       rx_rd,
  output logic       rx_empty,
  output logic       rx_overflow,
  output logic [7:0] txdata,
  output logic       txclk,
  input  logic       txready,
  input  logic [7:0] rxdata,
  output logic       rxclk,
  input  logic       rxready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [7:0]    TO_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_SETUP, TX_STROBE, TX_WAIT_LOW, TX_WAIT_HIGH
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_CAPTURE, RX_ACK, RX_WAIT_LOW
  } rx_state_t;

  logic [SYNC_STAGES-1:0] r_txr_sync, r_rxr_sync;
  logic w_txr_s, w_rxr_s;

  tx_state_t r_tx_state, w_tx_next;
  rx_state_t r_rx_state, w_rx_next;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [CW-1:0] r_tx_count;
  logic [7:0]    r_tx_timer;
  logic [7:0]    r_txdata;
  logic          r_txclk;
  logic          w_tx_push, w_tx_pop, w_tx_load, w_txclk_d;

  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wptr, r_rx_rptr, w_rx_rptr_nxt;
  logic [CW-1:0] r_rx_count;
  logic [7:0]    r_rx_timer;
  logic [7:0]    r_rx_rdata;
  logic          r_rxclk, r_rx_overflow;
  logic          w_rx_push, w_rx_pop, w_rx_drop, w_rxclk_d;

  // Both handshake inputs come from the serial-clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txr_sync <= '0;
      r_rxr_sync <= '0;
    end else begin
      r_txr_sync <= {r_txr_sync[SYNC_STAGES-2:0], txready};
      r_rxr_sync <= {r_rxr_sync[SYNC_STAGES-2:0], rxready};
    end
  end

  assign w_txr_s = r_txr_sync[SYNC_STAGES-1];
  assign w_rxr_s = r_rxr_sync[SYNC_STAGES-1];

  // ---------------- TX side ----------------
  assign w_tx_push = tx_wr && !tx_full;

  // NOTE: FIFO storage has no reset; pointers and counts alone define validity.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
      r_tx_timer <= '0;
      r_txdata   <= '0;
      r_txclk    <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_txclk    <= w_txclk_d;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
      r_tx_timer <= (r_tx_state == TX_WAIT_LOW) ? r_tx_timer + 1'b1 : '0;
      if (w_tx_load) r_txdata <= r_tx_mem[r_tx_rptr];
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    unique case (r_tx_state)
      TX_IDLE:      if (r_tx_count != '0 && w_txr_s) w_tx_next = TX_SETUP;
      TX_SETUP:     w_tx_next = TX_STROBE;
      TX_STROBE:    w_tx_next = TX_WAIT_LOW;
      TX_WAIT_LOW:  if (!w_txr_s || r_tx_timer == TO_LAST) w_tx_next = TX_WAIT_HIGH;
      TX_WAIT_HIGH: if (w_txr_s) w_tx_next = TX_IDLE;
      default:      w_tx_next = TX_IDLE;
    endcase
  end

  // txclk is registered from the next state so the wrapper sees a clean edge.
  always_comb begin
    w_tx_load = (r_tx_state == TX_IDLE)     && (w_tx_next == TX_SETUP);
    w_tx_pop  = (r_tx_state == TX_WAIT_LOW) && (w_tx_next == TX_WAIT_HIGH);
    w_txclk_d = (w_tx_next == TX_STROBE);
  end

  assign tx_full  = (r_tx_count == FULL_CNT);
  assign tx_empty = (r_tx_count == '0) && (r_tx_state == TX_IDLE);
  assign txdata   = r_txdata;
  assign txclk    = r_txclk;

  // ---------------- RX side ----------------
  assign w_rx_rptr_nxt = r_rx_rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= rxdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state    <= RX_IDLE;
      r_rx_wptr     <= '0;
      r_rx_rptr     <= '0;
      r_rx_count    <= '0;
      r_rx_timer    <= '0;
      r_rx_rdata    <= '0;
      r_rxclk       <= 1'b0;
      r_rx_overflow <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_rxclk    <= w_rxclk_d;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= w_rx_rptr_nxt;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
      r_rx_timer <= (r_rx_state == RX_WAIT_LOW) ? r_rx_timer + 1'b1 : '0;
      if (w_rx_drop) r_rx_overflow <= 1'b1;
      // The incoming byte bypasses memory whenever it becomes the new head.
      if (w_rx_push && (r_rx_count == '0 || (w_rx_pop && r_rx_count == ONE_CNT)))
        r_rx_rdata <= rxdata;
      else if (w_rx_pop && r_rx_count > ONE_CNT)
        r_rx_rdata <= r_rx_mem[w_rx_rptr_nxt];
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    unique case (r_rx_state)
      RX_IDLE:     if (w_rxr_s) w_rx_next = RX_CAPTURE;
      RX_CAPTURE:  w_rx_next = RX_ACK;
      RX_ACK:      w_rx_next = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!w_rxr_s || r_rx_timer == TO_LAST) w_rx_next = RX_IDLE;
      default:     w_rx_next = RX_IDLE;
    endcase
  end

  // A full FIFO still accepts the byte when the head is popped in the same cycle.
  always_comb begin
    w_rx_pop  = rx_rd && (r_rx_count != '0);
    w_rx_push = (r_rx_state == RX_CAPTURE) && ((r_rx_count != FULL_CNT) || w_rx_pop);
    w_rx_drop = (r_rx_state == RX_CAPTURE) && !w_rx_push;
    w_rxclk_d = (w_rx_next == RX_ACK);
  end

  assign rx_empty    = (r_rx_count == '0);
  assign rx_rdata    = r_rx_rdata;
  assign rx_overflow = r_rx_overflow;
  assign rxclk       = r_rxclk;

endmodule

// File: tb/tb_uart_byte_port.sv
// Bench for uart_byte_port: UART-side models for both handshakes, byte
// scoreboards for TX and RX, and a table of FIFO-fill vectors.
module tb_uart_byte_port;

  localparam int DEPTH       = 8;
  localparam int ACK_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_wdata = '0;
  logic       tx_wr = 1'b0;
  logic       tx_full, tx_empty;
  logic [7:0] rx_rdata;
  logic       rx_rd = 1'b0;
  logic       rx_empty, rx_overflow;
  logic [7:0] txdata;
  logic       txclk;
  logic       txready = 1'b1;
  logic [7:0] rxdata = '0;
  logic       rxclk;
  logic       rxready = 1'b0;

  uart_byte_port #(.DEPTH(DEPTH), .SYNC_STAGES(2), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_rdata(rx_rdata), .rx_rd(rx_rd), .rx_empty(rx_empty), .rx_overflow(rx_overflow),
    .txdata(txdata), .txclk(txclk), .txready(txready),
    .rxdata(rxdata), .rxclk(rxclk), .rxready(rxready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tx_pulses = 0;
  int rx_pulses = 0;
  int tx_mode = 0;            // 0: txready held 1, 1: handshake, 2: txready held 0
  logic [7:0] tx_exp [$];
  logic [7:0] rx_exp [$];
  int tx_rise_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_txdata"},   txdata, 8'h00);
    check({tag, "_txclk"},    txclk, 1'b0);
    check({tag, "_rxclk"},    rxclk, 1'b0);
    check({tag, "_overflow"}, rx_overflow, 1'b0);
    check({tag, "_tx_full"},  tx_full, 1'b0);
    check({tag, "_tx_empty"}, tx_empty, 1'b1);
    check({tag, "_rx_empty"}, rx_empty, 1'b1);
    check({tag, "_rx_rdata"}, rx_rdata, 8'h00);
  endtask

  // UART transmit side: scoreboards each txclk rise and drives txready.
  initial begin : tx_model
    logic prev_clk;
    logic [7:0] prev_data;
    int drop_in, raise_in;
    prev_clk = 1'b0; prev_data = '0; drop_in = -1; raise_in = -1;
    forever begin
      tick();
      if (txclk && !prev_clk) begin
        tx_pulses++;
        tx_rise_cyc.push_back(cyc);
        check("tx_setup_stable", txdata, prev_data);
        check("tx_strobe_expected", 32'(tx_exp.size() != 0), 1);
        if (tx_exp.size() != 0) check("tx_byte", txdata, tx_exp.pop_front());
        if (tx_mode == 1) drop_in = 2;
      end
      if (prev_clk) check("txclk_width", txclk, 1'b0);
      if (drop_in > 0) drop_in--;
      if (drop_in == 0) begin
        txready = 1'b0; drop_in = -1; raise_in = 10;
      end else if (raise_in > 0) begin
        raise_in--;
        if (raise_in == 0) begin txready = 1'b1; raise_in = -1; end
      end else if (drop_in < 0) begin
        txready = (tx_mode != 2);
      end
      prev_clk  = txclk;
      prev_data = txdata;
    end
  end

  initial begin : rx_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      tick();
      if (rxclk && !prev) rx_pulses++;
      if (prev) check("rxclk_width", rxclk, 1'b0);
      prev = rxclk;
    end
  end

  // UART receive side: present a byte, wait for the ack, drop rxready 3 cycles later.
  task automatic rx_send(input logic [7:0] b);
    bit seen;
    if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
    rxdata = b;
    rxready = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (rxclk) seen = 1;
    end
    check("rx_ack_seen", 32'(seen), 1);
    repeat (3) tick();
    rxready = 1'b0;
    repeat (6) tick();
  endtask

  task automatic rx_read();
    check("rx_not_empty", rx_empty, 1'b0);
    if (rx_exp.size() != 0) check("rx_rdata", rx_rdata, rx_exp.pop_front());
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       exp_full;
    logic       exp_empty;
  } tx_vec_t;

  tx_vec_t vecs [10];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int base, model_cnt;
    bit done, accept;

    for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, 8'(i), (i == 7), 1'b0};
    vecs[8] = '{1'b1, 8'h99, 1'b1, 1'b0};   // write while full: ignored
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0};

    // Reset with txready=1, rxready=0.
    #3 reset = 1'b1;
    #1 check_reset_values("async_reset");
    tick(); tick();
    check_reset_values("reset");
    reset = 1'b0;
    repeat (20) tick();
    check("idle_tx_pulses", tx_pulses, 0);
    check("idle_rx_pulses", rx_pulses, 0);
    check("idle_tx_empty", tx_empty, 1'b1);

    // TX single byte with a full handshake.
    tx_mode = 1;
    base = tx_pulses;
    tx_wdata = 8'h41; tx_wr = 1'b1;
    tick();
    tx_wr = 1'b0;
    tx_exp.push_back(8'h41);
    check("tx1_not_empty", tx_empty, 1'b0);
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (tx_empty) done = 1;
    end
    check("tx1_drained", 32'(done), 1);
    check("tx1_txready_high", txready, 1'b1);
    check("tx1_pulses", tx_pulses - base, 1);
    check("tx1_txdata_hold", txdata, 8'h41);

    // TX burst into a stalled UART, then timeout-paced drain.
    tx_mode = 2;
    repeat (6) tick();
    base = tx_pulses;
    model_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tx_wdata = vecs[i].data;
      tx_wr = vecs[i].wr;
      accept = vecs[i].wr && (model_cnt < DEPTH);
      tick();
      tx_wr = 1'b0;
      if (accept) begin
        tx_exp.push_back(vecs[i].data);
        model_cnt++;
      end
      check("burst_full", tx_full, vecs[i].exp_full);
      check("burst_empty", tx_empty, vecs[i].exp_empty);
    end
    check("burst_no_strobe", tx_pulses - base, 0);
    tx_mode = 0;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (tx_empty) done = 1;
    end
    check("burst_drained", 32'(done), 1);
    check("burst_pulses", tx_pulses - base, 8);
    check("burst_scoreboard_empty", tx_exp.size(), 0);
    for (int i = tx_rise_cyc.size() - 7; i < tx_rise_cyc.size(); i++)
      if (i > 0) check("timeout_byte_period", tx_rise_cyc[i] - tx_rise_cyc[i-1], ACK_TIMEOUT + 4);

    // RX single byte.
    base = rx_pulses;
    rx_send(8'h5A);
    check("rx1_pulses", rx_pulses - base, 1);
    check("rx1_not_empty", rx_empty, 1'b0);
    rx_read();
    check("rx1_empty_after_read", rx_empty, 1'b1);

    // RX overflow: nine bytes, no reads.
    base = rx_pulses;
    for (int i = 0; i < 9; i++) begin
      rx_send(8'h80 + 8'(i));
      if (i == 7) check("ovf_not_yet", rx_overflow, 1'b0);
    end
    check("ovf_pulses", rx_pulses - base, 9);
    check("ovf_flag", rx_overflow, 1'b1);
    for (int i = 0; i < 8; i++) rx_read();
    check("ovf_drained_empty", rx_empty, 1'b1);
    check("ovf_sticky", rx_overflow, 1'b1);

    // Asynchronous reset while the RX FSM is in CAPTURE.
    rxdata = 8'hEE;
    rxready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    rxready = 1'b0;
    #1 check_reset_values("capture_reset");
    tick();
    reset = 1'b0;
    base = rx_pulses;
    repeat (10) tick();
    check("post_reset_rx_pulses", rx_pulses - base, 0);
    check("post_reset_rx_empty", rx_empty, 1'b1);
    check("post_reset_overflow", rx_overflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
